q47_preimage_search: RTL and testbench



---
 rtl/q47_preimage_search.sv | 144 ++++++++++++++
 tb/tb_q47_preimage_search.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/q47_preimage_search.sv
// q47_preimage_search: enumerates every 4-bit input code {A,B,C,D} that the Q47
// function maps onto a requested {Fa,Fb}, one code per valid/ready transfer.
// Latency: start -> first SCAN 1 cycle; each non-match 1 cycle, each match 2 cycles
// (plus stall cycles); done pulses in cycle 17+M with out_ready held high.
// Backpressure: out_code/out_valid hold while out_ready is low; the scan pauses.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, target     search request (sampled in IDLE only) and {Fa,Fb} to match
//   out_valid/out_ready/out_code  matching-code stream
//   busy, done        activity flag and end-of-search pulse
//   match_count       codes emitted by the last search (held until next start)
// Build option: define Q47_DESCENDING_EN to scan from 15 down to 0.
module q47_preimage_search (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] target,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_code,
  output logic       busy,
  output logic       done,
  output logic [4:0] match_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

`ifdef Q47_DESCENDING_EN
  localparam logic [3:0] IDX_FIRST = 4'd15;
  localparam logic [3:0] IDX_LAST  = 4'd0;
`else
  localparam logic [3:0] IDX_FIRST = 4'd0;
  localparam logic [3:0] IDX_LAST  = 4'd15;
`endif

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_idx;
  logic [1:0] r_target;
  logic [3:0] r_code;
  logic [4:0] r_count;

  logic [1:0] w_f;
  logic       w_match;
  logic       w_last;
  logic [3:0] w_idx_step;

  // Q47 function of the current index; bit order {A,B,C,D} = r_idx[3:0].
  always_comb begin
    w_f = 2'b00;
    case (r_idx[3:2])
      2'b00: w_f = {r_idx[0], r_idx[1] ^ r_idx[0]};
      2'b01: w_f = {~r_idx[1] & ~r_idx[0], r_idx[0]};
      2'b10: w_f = {r_idx[1] & r_idx[0], r_idx[1] | ~r_idx[0]};
      default: w_f = {1'b1, r_idx[0]};
    endcase
  end

  assign w_match = (w_f == r_target);
  // End of scan is an explicit compare on the final index, not a counter wrap.
  assign w_last  = (r_idx == IDX_LAST);

`ifdef Q47_DESCENDING_EN
  assign w_idx_step = r_idx - 4'd1;
`else
  assign w_idx_step = r_idx + 4'd1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_next    = r_state;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_SCAN;
      end
      S_SCAN: begin
        if (w_match)     w_next = S_EMIT;
        else if (w_last) w_next = S_DONE;
      end
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = w_last ? S_DONE : S_SCAN;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: target capture, index walk, emitted code and match counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= 4'd0;
      r_target <= 2'd0;
      r_code   <= 4'd0;
      r_count  <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_target <= target;
            r_idx    <= IDX_FIRST;
            r_count  <= 5'd0;
          end
        end
        S_SCAN: begin
          if (w_match) begin
            r_code  <= r_idx;
            r_count <= r_count + 5'd1;
          end else if (!w_last) begin
            r_idx <= w_idx_step;
          end
        end
        S_EMIT: begin
          // Index advances only on the transfer so the scan resumes after it.
          if (out_ready && !w_last) r_idx <= w_idx_step;
        end
        default: ;
      endcase
    end
  end

  assign out_code    = r_code;
  assign match_count = r_count;

endmodule

// File: tb/tb_q47_preimage_search.sv
module tb_q47_preimage_search;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] target;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_code;
  logic       busy;
  logic       done;
  logic [4:0] match_count;

  int total = 0;
  int bad   = 0;

  // Preimage sets of the Q47 function, one bit per input code, indexed by {Fa,Fb}.
  logic [15:0] pre_mask [4];

  q47_preimage_search dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .target     (target),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .busy       (busy),
    .done       (done),
    .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Runs one search. mode: 0 ready tied high, 1 ready toggles, 2 ready random.
  // inject: pulse start with another target while busy.
  task automatic run_search(input logic [1:0] t, input int mode, input bit inject);
    int   exp_q[$];
    int   k;
    int   stalls;
    int   cyc;
    bit   seen_done;
    bit   stalled;
    int   held_code;
    logic ready_phase;
    exp_q = {};
    for (int c = 0; c < 16; c++) begin
      if (pre_mask[t][c]) begin
`ifdef Q47_DESCENDING_EN
        exp_q.push_front(c);
`else
        exp_q.push_back(c);
`endif
      end
    end
    k = 0; stalls = 0; seen_done = 0; stalled = 0; held_code = 0;
    ready_phase = 1'b1;
    target = t;
    start  = 1'b1;
    out_ready = 1'b1;
    tick();
    cyc = 1;
    start  = 1'b0;
    target = ~t;
    chk("busy_after_start", busy, 1);
    for (int n = 0; n < 200 && !seen_done; n++) begin
      case (mode)
        0: out_ready = 1'b1;
        1: begin out_ready = ready_phase; ready_phase = ~ready_phase; end
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      start = inject && (n == 3 || n == 9);
      if (out_valid) begin
        if (stalled) chk("code_stable", out_code, held_code);
        else if (k < exp_q.size()) chk("code", out_code, exp_q[k]);
        else chk("extra_code", k, exp_q.size());
        if (out_ready) begin
          k++;
          stalled = 0;
        end else begin
          stalls++;
          stalled = 1;
          held_code = out_code;
        end
      end
      if (done) begin
        seen_done = 1;
        chk("done_cycle", cyc, 17 + exp_q.size() + stalls);
        chk("codes_emitted", k, exp_q.size());
        // A start in the done cycle must be ignored.
        start  = 1'b1;
        target = ~t;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("search_finished", seen_done, 1);
    chk("busy_after_done", busy, 0);
    chk("match_count", match_count, exp_q.size());
    tick();
    chk("busy_idle_hold", busy, 0);
    chk("count_hold", match_count, exp_q.size());
  endtask

  initial begin
    int first_code;
    bit got_second;
    pre_mask[0] = 16'h0241;  // 0,6,9
    pre_mask[1] = 16'h05A4;  // 2,5,7,8,10
    pre_mask[2] = 16'h5018;  // 3,4,12,14
    pre_mask[3] = 16'hA802;  // 1,11,13,15
    rst = 1'b1; start = 1'b0; target = 2'd0; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_code",  out_code, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_count", match_count, 0);
    tick();

    // Directed searches from the plan.
    run_search(2'b00, 0, 0);
    run_search(2'b01, 1, 0);
    run_search(2'b11, 0, 0);
    run_search(2'b10, 0, 1);

    // Reset during the emit of the second code of target 10.
    first_code = pre_mask[2][3] ? 3 : 14;
`ifdef Q47_DESCENDING_EN
    first_code = 14;
`else
    first_code = 3;
`endif
    got_second = 0;
    target = 2'b10; start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int n = 0; n < 60 && !got_second; n++) begin
      out_ready = 1'b0;
      if (out_valid) begin
        if (out_code == first_code[3:0]) out_ready = 1'b1;
        else got_second = 1;
      end
      if (!got_second) tick();
    end
    chk("reached_second_emit", got_second, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_code",  out_code, 0);
    chk("abort_busy",  busy, 0);
    chk("abort_done",  done, 0);
    chk("abort_count", match_count, 0);
    tick();
    run_search(2'b10, 0, 0);

    // Randomized searches.
    for (int r = 0; r < 12; r++) begin
      run_search(2'($urandom_range(0, 3)), $urandom_range(0, 2), bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
